// File: rtl/master_control_pkg.sv
// Shared definitions for the Chip2Chip link, used by both master and slave sides.
package master_control_pkg;

    // Link controller states, 2-bit encoding shared across boards
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK    = 2'd1,
        SEND_DATA   = 2'd2,
        HOLD_NOTICE = 2'd3
    } link_state_t;

    localparam int DATA_W_DEF = 3;

endpackage

// File: rtl/master_control_delay_counter.sv
// Down-counting delay timer: done pulses for one cycle CYCLES cycles after start.
module delay_counter #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Load on start (restarting any count in progress), then run down to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count is 1 so done lands exactly CYCLES edges after start is sampled
    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/master_control.sv
// Master-side Chip2Chip link controller: request/ack handshake, then a fixed valid window.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for a send pulse
// WAIT_ACK    | request raised, waiting for a synchronized ack rising edge
// SEND_DATA   | valid high for VALID_HOLD cycles with latched data
// HOLD_NOTICE | notice LED held for DELAY_CYCLES before returning to IDLE
module master_control
    import master_control_pkg::*;
#(
    parameter int DELAY_CYCLES = 100_000_000,
    parameter int VALID_HOLD   = 4,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              ack,
    output logic              request,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              notice,
    output logic              busy
);

    localparam int VC_W = $clog2(VALID_HOLD + 1);

    link_state_t      state, state_nx;
    logic             ack_meta, ack_s, ack_s_d, ack_rise;
    logic [VC_W-1:0]  vcnt;
    logic             vcnt_load, dly_start, dly_done, data_load;

    // Two-flop synchronizer for the slave's ack, plus a delayed copy for edge detect.
    // The rise pulse is registered so the FSM advances one edge after detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
            ack_s_d  <= 1'b0;
            ack_rise <= 1'b0;
        end else begin
            ack_meta <= ack;
            ack_s    <= ack_meta;
            ack_s_d  <= ack_s;
            ack_rise <= ack_s & ~ack_s_d;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Valid-window down-counter, loaded on the ack that starts SEND_DATA
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vcnt <= '0;
        end else if (vcnt_load) begin
            vcnt <= VC_W'(VALID_HOLD);
        end else if (state == SEND_DATA && vcnt != '0) begin
            vcnt <= vcnt - 1'b1;
        end
    end

    // Data register, only written by an accepted send so it is frozen while valid is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (data_load) begin
            data <= sw_data;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_nx  = state;
        vcnt_load = 1'b0;
        dly_start = 1'b0;
        data_load = 1'b0;
        request   = 1'b0;
        valid     = 1'b0;
        notice    = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    state_nx  = WAIT_ACK;
                    data_load = 1'b1;
                end
            end
            WAIT_ACK: begin
                request = 1'b1;
                notice  = 1'b1;
                if (ack_rise) begin
                    state_nx  = SEND_DATA;
                    vcnt_load = 1'b1;
                end
            end
            SEND_DATA: begin
                valid  = 1'b1;
                notice = 1'b1;
                if (vcnt == VC_W'(1)) begin
                    state_nx  = HOLD_NOTICE;
                    dly_start = 1'b1;
                end
            end
            HOLD_NOTICE: begin
                notice = 1'b1;
                if (dly_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    delay_counter #(
        .CYCLES (DELAY_CYCLES)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .start (dly_start),
        .done  (dly_done)
    );

endmodule
